nanci_mesh: RTL and testbench
=============================

# nanci_mesh

Self-contained SQRT_N x SQRT_N mesh of processing elements (PEs) that routes write packets by sorting them on their address field and then commits each packet's data into the memory of the destination PE. It is the top of the Nanci mesh datapath: packet generation, shearsort routing and the per-PE memory write all live inside it. The only externally driven inputs are clock and reset. Results are exposed on a flattened debug bus plus a done flag.

## Interface
- N, 4: number of PEs; N = SQRT_N*SQRT_N.
- SQRT_N, 2: mesh side length; power of 2, at least 2.
- ADDR_WIDTH, 2: packet address width; equals log2(N).
- DATA_WIDTH, 2: packet data and PE memory width.
- SORT_CYCLES, 4: odd-even transposition steps per sort phase; at least SQRT_N.
- Derived, not overridable: WIDTH = ADDR_WIDTH + DATA_WIDTH, the packet width.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-low; clears or initialises all state.
- mem_flat  out  N*DATA_WIDTH  memory of PE k on bits [k*DATA_WIDTH +: DATA_WIDTH].
- done  out  1  high once the write phase has completed.

## Operation
- PE k sits at row r = k / SQRT_N and column c = k % SQRT_N, in row-major order.
- Each PE holds one packet register of WIDTH bits, {addr, data}, and one memory register of DATA_WIDTH bits.
- Reset contents:
  - PE k's packet = {addr = N-1-k, data = k[DATA_WIDTH-1:0]}, a reversal-permutation write.
  - All memories = 0, done = 0, phase and step counters = 0.
- Compare-exchange:
  - Compares the addr field only; the data field travels with its addr.
  - Addresses are unique, so every result is deterministic.
- Sort phases use odd-even transposition along a line of SQRT_N PEs.
  - Step t even: pairs (0,1), (2,3), ...
  - Step t odd: pairs (1,2), (3,4), ...
  - Ascending order places the smaller addr at the lower index.
- Phase sequence, with L = log2(SQRT_N) + 1:
  - Repeat L times: a row phase, then a column phase.
  - Row phase: snake order, even rows ascending by column, odd rows descending.
  - Column phase: every column ascending by row.
  - Then one final row phase with all rows ascending.
  - Total phases P = 2L + 1; each phase lasts exactly SORT_CYCLES steps.
- After sorting, PE k holds the packet with addr == k.
- Write cycle:
  - Each PE with packet.addr == its own index writes packet.data into its memory.
  - A PE with no match leaves its memory unchanged; this cannot occur for the built-in permutation.
- Done state:
  - done = 1; packets and memories hold.
  - No further activity until the next reset.
- Resulting memory of PE k = (N-1-k)[DATA_WIDTH-1:0].

## Timing
- While rst = 0: mem_flat = 0, done = 0, and packets hold their initial values. Reset takes effect immediately, without waiting for a clock edge.
- Sort steps:
  - Edge 1 after rst deasserts performs sort step 0 of phase 0.
  - Exactly one compare-exchange step per edge for P*SORT_CYCLES edges.
- Edge P*SORT_CYCLES + 1 performs the memory write and sets done.
  - Default parameters: P = 5, so done and final mem_flat appear after edge 21.
  - N = 16: P = 7, so after edge 29.
- mem_flat:
  - Registered, stays 0 until the write edge.
  - Changes exactly once, at the write edge.
- done is registered and never deasserts except by reset.
- Reset asserted mid-sort or after done:
  - All state immediately returns to reset values.
  - The full sequence reruns from edge 1 after release, with identical results.

## Test plan
- Defaults (N=4): hold rst low 2 cycles, release, run 100 cycles -> mem_flat = {PE3=0, PE2=1, PE1=2, PE0=3}, i.e. 8'b00_01_10_11; done = 1.
- Latency, defaults: done = 0 and mem_flat = 0 through edge 20; both final after edge 21.
- Reset behaviour: assert rst low mid-clock at cycle 10 -> mem_flat = 0 and done = 0 immediately; after release, same final values at edge 21.
- Scaling: N=16, SQRT_N=4, ADDR_WIDTH=4, DATA_WIDTH=4 -> PE k memory = 15-k for all k; done after edge 29.
- Truncation: defaults with DATA_WIDTH=1 -> PE k memory = (3-k) & 1, giving PE0..PE3 = 1, 0, 1, 0.
- Stability: after done, run 50 more cycles -> mem_flat and done unchanged.

Source files
------------

// File: rtl/nanci_mesh.sv
// SQRT_N x SQRT_N PE mesh: shearsorts write packets by address, then each PE
// commits the data of the packet addressed to it into its memory register.
//
// state    | meaning
// ST_SORT  | one odd-even compare-exchange step per edge, phase/step counting
// ST_WRITE | every PE whose packet addr matches its index writes the data
// ST_DONE  | everything holds until reset
module nanci_mesh #(
  parameter int N           = 4,
  parameter int SQRT_N      = 2,
  parameter int ADDR_WIDTH  = 2,
  parameter int DATA_WIDTH  = 2,
  parameter int SORT_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [N*DATA_WIDTH-1:0] mem_flat,
  output logic                    done
);

  localparam int WIDTH   = ADDR_WIDTH + DATA_WIDTH;
  localparam int L       = $clog2(SQRT_N) + 1;
  localparam int P       = 2 * L + 1;
  localparam int PHASE_W = $clog2(P);
  localparam int STEP_W  = $clog2(SORT_CYCLES);

  typedef enum logic [1:0] {ST_SORT, ST_WRITE, ST_DONE} state_t;

  state_t               state_q, state_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic [STEP_W-1:0]    step_q, step_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     pkt_q [N];
  logic [WIDTH-1:0]     pkt_d [N];
  logic [DATA_WIDTH-1:0] mem_q [N];
  logic [DATA_WIDTH-1:0] mem_d [N];
  logic [WIDTH-1:0]     sort_pkt [N];
  logic [DATA_WIDTH-1:0] wr_val [N];

  logic final_phase, col_phase;
  assign final_phase = (phase_q == PHASE_W'(P - 1));
  // Phases alternate row/column; the last phase (even index) is a plain row sort.
  assign col_phase   = phase_q[0] && !final_phase;

  for (genvar k = 0; k < N; k++) begin : g_pe
    localparam int R = k / SQRT_N;
    localparam int C = k % SQRT_N;
    // Edge PEs with no partner point at themselves, which makes the exchange a no-op.
    localparam int ROW_UP = (C < SQRT_N - 1) ? k + 1 : k;
    localparam int ROW_DN = (C > 0) ? k - 1 : k;
    localparam int COL_UP = (R < SQRT_N - 1) ? k + SQRT_N : k;
    localparam int COL_DN = (R > 0) ? k - SQRT_N : k;
    localparam logic R_ODD = ((R % 2) == 1);
    localparam logic C_ODD = ((C % 2) == 1);

    logic             lower, desc, keep_min, me_less;
    logic [WIDTH-1:0] partner, nxt;

    always_comb begin
      lower = ((col_phase ? R_ODD : C_ODD) == step_q[0]);
      if (col_phase) partner = lower ? pkt_q[COL_UP] : pkt_q[COL_DN];
      else           partner = lower ? pkt_q[ROW_UP] : pkt_q[ROW_DN];
      desc     = !col_phase && !final_phase && R_ODD;
      keep_min = lower ^ desc;
      me_less  = pkt_q[k][WIDTH-1 -: ADDR_WIDTH] < partner[WIDTH-1 -: ADDR_WIDTH];
      if (keep_min) nxt = me_less ? pkt_q[k] : partner;
      else          nxt = me_less ? partner : pkt_q[k];
    end

    assign sort_pkt[k] = nxt;
    assign wr_val[k]   = (pkt_q[k][WIDTH-1 -: ADDR_WIDTH] == ADDR_WIDTH'(k))
                         ? pkt_q[k][DATA_WIDTH-1:0] : mem_q[k];
    assign mem_flat[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[k];
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    step_d  = step_q;
    done_d  = done_q;
    pkt_d   = pkt_q;
    mem_d   = mem_q;
    case (state_q)
      ST_SORT: begin
        pkt_d = sort_pkt;
        if (step_q == STEP_W'(SORT_CYCLES - 1)) begin
          step_d = '0;
          if (final_phase) state_d = ST_WRITE;
          else             phase_d = phase_q + PHASE_W'(1);
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end
      ST_WRITE: begin
        mem_d   = wr_val;
        done_d  = 1'b1;
        state_d = ST_DONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_SORT;
      phase_q <= '0;
      step_q  <= '0;
      done_q  <= 1'b0;
      for (int k = 0; k < N; k++) begin
        pkt_q[k] <= {ADDR_WIDTH'(N - 1 - k), DATA_WIDTH'(k)};
        mem_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      step_q  <= step_d;
      done_q  <= done_d;
      pkt_q   <= pkt_d;
      mem_q   <= mem_d;
    end
  end

  assign done = done_q;

endmodule

// File: tb/tb_nanci_mesh.sv
// Bench for nanci_mesh: three instances (defaults, 4x4 mesh, 1-bit data) share
// one clock and reset; reset timing is randomized and results come from a model.
module tb_nanci_mesh;

  logic        clk;
  logic        rst;
  logic [7:0]  mem4;
  logic        done4;
  logic [63:0] mem16;
  logic        done16;
  logic [3:0]  mem1;
  logic        done1;

  int n_checks = 0;
  int n_fail   = 0;

  // Write edge = (2*(log2(side)+1)+1) phases * 4 steps + 1.
  localparam int WR4  = (2 * (1 + 1) + 1) * 4 + 1;
  localparam int WR16 = (2 * (2 + 1) + 1) * 4 + 1;

  logic [7:0]  f4;
  logic [63:0] f16;
  logic [3:0]  f1;

  nanci_mesh dut4 (.clk(clk), .rst(rst), .mem_flat(mem4), .done(done4));
  nanci_mesh #(.N(16), .SQRT_N(4), .ADDR_WIDTH(4), .DATA_WIDTH(4), .SORT_CYCLES(4))
    dut16 (.clk(clk), .rst(rst), .mem_flat(mem16), .done(done16));
  nanci_mesh #(.DATA_WIDTH(1))
    dut1 (.clk(clk), .rst(rst), .mem_flat(mem1), .done(done1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reversal permutation: PE k ends up with data (N-1-k) truncated to DATA_WIDTH.
  function automatic logic [7:0] final4();
    logic [7:0] v;
    v = '0;
    for (int k = 0; k < 4; k++) v[k*2 +: 2] = 2'(3 - k);
    return v;
  endfunction

  function automatic logic [63:0] final16();
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < 16; k++) v[k*4 +: 4] = 4'(15 - k);
    return v;
  endfunction

  function automatic logic [3:0] final1();
    logic [3:0] v;
    v = '0;
    for (int k = 0; k < 4; k++) v[k] = 1'((3 - k) & 1);
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (mem4 !== 8'h0) begin n_fail++; $display("FAIL reset_mem4 got %h expected 00", mem4); end
    n_checks++; if (done4 !== 1'b0) begin n_fail++; $display("FAIL reset_done4 got %b expected 0", done4); end
    n_checks++; if (mem16 !== 64'h0) begin n_fail++; $display("FAIL reset_mem16 got %h expected 0", mem16); end
    n_checks++; if (done16 !== 1'b0) begin n_fail++; $display("FAIL reset_done16 got %b expected 0", done16); end
    n_checks++; if (mem1 !== 4'h0) begin n_fail++; $display("FAIL reset_mem1 got %h expected 0", mem1); end
  endtask

  task automatic test_latency();
    rst = 1'b1;
    for (int e = 1; e <= 35; e++) begin
      @(posedge clk); @(negedge clk);
      n_checks++;
      if (mem4 !== ((e >= WR4) ? f4 : 8'h0)) begin
        n_fail++; $display("FAIL latency_mem4 edge %0d got %h expected %h", e, mem4, (e >= WR4) ? f4 : 8'h0);
      end
      n_checks++;
      if (done4 !== (e >= WR4)) begin
        n_fail++; $display("FAIL latency_done4 edge %0d got %b expected %b", e, done4, e >= WR4);
      end
      n_checks++;
      if (mem16 !== ((e >= WR16) ? f16 : 64'h0)) begin
        n_fail++; $display("FAIL latency_mem16 edge %0d got %h expected %h", e, mem16, (e >= WR16) ? f16 : 64'h0);
      end
      n_checks++;
      if (done16 !== (e >= WR16)) begin
        n_fail++; $display("FAIL latency_done16 edge %0d got %b expected %b", e, done16, e >= WR16);
      end
      n_checks++;
      if (mem1 !== ((e >= WR4) ? f1 : 4'h0) || done1 !== (e >= WR4)) begin
        n_fail++; $display("FAIL latency_trunc edge %0d got %h/%b expected %h/%b", e, mem1, done1, (e >= WR4) ? f1 : 4'h0, e >= WR4);
      end
    end
  endtask

  task automatic test_stability();
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); @(negedge clk);
      n_checks++;
      if (mem4 !== f4 || done4 !== 1'b1 || mem16 !== f16 || done16 !== 1'b1 || mem1 !== f1 || done1 !== 1'b1) begin
        n_fail++;
        $display("FAIL stability cycle %0d got %h/%b %h/%b %h/%b expected %h/1 %h/1 %h/1",
                 i, mem4, done4, mem16, done16, mem1, done1, f4, f16, f1);
      end
    end
  endtask

  task automatic rerun_and_check(input string tag);
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk); @(negedge clk);
      n_checks++;
      if (done4 !== (e >= WR4) || done16 !== (e >= WR16)) begin
        n_fail++; $display("FAIL %s_done edge %0d got %b/%b expected %b/%b", tag, e, done4, done16, e >= WR4, e >= WR16);
      end
      if (e == WR4 - 1) begin
        n_checks++;
        if (mem4 !== 8'h0) begin n_fail++; $display("FAIL %s_mem4_early got %h expected 00", tag, mem4); end
      end
      if (e == WR4) begin
        n_checks++;
        if (mem4 !== f4 || mem1 !== f1) begin
          n_fail++; $display("FAIL %s_mem4_final got %h/%h expected %h/%h", tag, mem4, mem1, f4, f1);
        end
      end
      if (e == WR16) begin
        n_checks++;
        if (mem16 !== f16) begin n_fail++; $display("FAIL %s_mem16_final got %h expected %h", tag, mem16, f16); end
      end
    end
  endtask

  task automatic async_reset_and_check(input string tag);
    #($urandom_range(1, 8));
    rst = 1'b0;
    #1;
    n_checks++;
    if (mem4 !== 8'h0 || done4 !== 1'b0 || mem16 !== 64'h0 || done16 !== 1'b0 || mem1 !== 4'h0 || done1 !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_async_clear got %h/%b %h/%b %h/%b expected all zero", tag, mem4, done4, mem16, done16, mem1, done1);
    end
    repeat ($urandom_range(1, 3)) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_mid_reset();
    int abort;
    abort = $urandom_range(1, WR16 - 1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (abort) @(posedge clk);
    async_reset_and_check("mid_reset");
    rerun_and_check("mid_reset");
  endtask

  task automatic test_reset_after_done();
    @(posedge clk);
    async_reset_and_check("after_done");
    rerun_and_check("after_done");
  endtask

  initial begin
    rst = 1'b0;
    f4  = final4();
    f16 = final16();
    f1  = final1();
    test_reset();
    test_latency();
    test_stability();
    for (int i = 0; i < 3; i++) test_mid_reset();
    test_reset_after_done();
    test_stability();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
